mcp3202_adc_reader: RTL and testbench
=====================================

# mcp3202_adc_reader

Free-running SPI master for a Microchip MCP3202 12-bit ADC. It repeatedly converts a single-ended channel and publishes each 12-bit result with a one-cycle valid strobe. It sits between the board-level ADC pins and the controller datapath, which consumes `sensor_reading` as its feedback sample.

## Interface
Parameters:
- `SCLK_HALF` (default 16): `sys_clk` cycles per SPI clock half-period. Default gives an SPI period of 32 cycles (320 ns at 100 MHz).
- `IDLE_CYCLES` (default 10): `sys_clk` cycles that `spi_cs_n` stays high before each frame, including the first frame after reset.
- `CHANNEL` (default 0): ODD/SIGN bit of the command. 0 selects CH0 and 1 selects CH1, both single-ended.

Ports:
- `sys_clk` input 1: system clock. All logic is on the rising edge.
- `sys_reset_n` input 1: one clock; reset is asynchronous and active-low.
- `spi_clk` output 1: SPI SCLK, mode 0. Idles low.
- `spi_miso` input 1: ADC DOUT.
- `spi_mosi` output 1: ADC DIN.
- `spi_cs_n` output 1: ADC chip select, active low.
- `sensor_reading` output 12: last completed conversion, MSB first.
- `reading_valid` output 1: one-cycle pulse when `sensor_reading` updates.

## Operation
- Reset values: `spi_cs_n`=1, `spi_clk`=0, `spi_mosi`=0, `sensor_reading`=0, `reading_valid`=0. The FSM enters IDLE with its counters cleared.
- IDLE state:
  - `spi_cs_n`=1 and `spi_clk`=0.
  - Counts `IDLE_CYCLES` edges, then enters XFER.
- XFER state: one frame of 17 SCLK cycles, numbered k=1..17.
  - MOSI command for k=1..4: start=1, SGL/DIFF=1, ODD/SIGN=`CHANNEL`, MSBF=1. MOSI is 0 for k≥5.
  - MISO on k=5 is the null bit and is ignored.
  - MISO on k=6..17 is B11..B0. Each bit is shifted into a 12-bit register, MSB first.
- End of frame:
  - `spi_cs_n` returns to 1.
  - The shift register is copied to `sensor_reading`.
  - `reading_valid` pulses for exactly 1 cycle.
  - The FSM returns to IDLE.
- Operation is continuous; there is no start input. `sensor_reading` holds its value between updates.
- Reset asserted at any point, including mid-frame, immediately forces all reset values.
  - A partial frame is discarded and never published.
  - After reset releases, the next frame starts only after a full IDLE period.

## Timing
Edge numbering:
- Edge 1 is the first `sys_clk` rising edge with `sys_reset_n` high.
- E0 is edge number `IDLE_CYCLES`, which is edge 10 by default. At E0, `spi_cs_n` falls and `spi_mosi` is driven with the start bit.
- H = `SCLK_HALF`.

SCLK edges:
- SCLK cycle k rises at E0 + H + 2H(k−1) and falls at E0 + 2Hk.
- With defaults, cycle k rises at E0+16+32(k−1) and falls at E0+32k.

MOSI:
- MOSI changes only at E0 and on SCLK falling edges.
- Command bit k is valid across rising edge k.

MISO sampling:
- MISO is captured at the `sys_clk` edge on which `spi_clk` is driven high.
- B11 is captured at rising edge k=6, i.e. E0+176 with defaults.

Frame end:
- Happens at the falling edge of k=17, E0+34H (E0+544 with defaults).
- At that same edge: `spi_cs_n`=1, `sensor_reading` updates, and `reading_valid`=1 for that single cycle.

Frame period:
- Frame period is 34H + `IDLE_CYCLES` cycles, which is 554 cycles with defaults.
- Next E0 = previous frame end + `IDLE_CYCLES`.

Sample-time arithmetic (defaults, reset released at 15 ns):
- E0 ≈ 115 ns.
- Data samples fall at 1875 ns + 320 ns·n, for n = 0..11.

## Test plan
- **Reset:** hold `sys_reset_n`=0 → `spi_cs_n`=1, `spi_clk`=0, `spi_mosi`=0, `sensor_reading`=0, `reading_valid`=0.
- **First frame, toggling MISO:** 100 MHz clock, reset released at 15 ns, MISO starts at 0 and toggles every 2000 ns.
  - First `reading_valid` rising edge near 5.55 µs.
  - `sensor_reading`=12'h7E0 at that edge.
- **Command bits:** sample `spi_mosi` at SCLK rising edges 1–4 → 1,1,0,1. `spi_mosi`=0 for edges 5–17.
- **Constant MISO:**
  - MISO held at 1 → 12'hFFF on every frame.
  - MISO held at 0 → 12'h000 on every frame.
- **Frame cadence:** `reading_valid` is high exactly 1 cycle per frame, and successive pulses are 554 cycles apart.
  - `spi_cs_n` is high for exactly 10 cycles between frames.
  - 17 SCLK pulses per frame.
- **Reset mid-frame:** assert reset after SCLK rising edge 8.
  - Outputs return to reset values immediately, with no `reading_valid` pulse.
  - After release, `spi_cs_n` falls on edge 10.

Source files
------------

// File: rtl/mcp3202_adc_reader.sv
`timescale 1ns/1ps
// MCP3202 free-running SPI reader: single-ended conversions on a fixed
// channel, each 12-bit result published with a one-cycle valid strobe.
module mcp3202_adc_reader #(
    parameter int SCLK_HALF   = 16,
    parameter int IDLE_CYCLES = 10,
    parameter int CHANNEL     = 0
) (
    input  logic        sys_clk,
    input  logic        sys_reset_n,
    output logic        spi_clk,
    input  logic        spi_miso,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic [11:0] sensor_reading,
    output logic        reading_valid
);

    localparam int HW = $clog2(SCLK_HALF + 1);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic          ODD_BIT   = CHANNEL[0];

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t        state;
    logic [HW-1:0] half_cnt;
    logic [IW-1:0] idle_cnt;
    logic [4:0]    bit_cnt;
    logic [2:0]    cmd_sr;
    logic [11:0]   shreg;

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state          <= IDLE;
            half_cnt       <= '0;
            idle_cnt       <= '0;
            bit_cnt        <= '0;
            cmd_sr         <= '0;
            shreg          <= '0;
            spi_clk        <= 1'b0;
            spi_mosi       <= 1'b0;
            spi_cs_n       <= 1'b1;
            sensor_reading <= '0;
            reading_valid  <= 1'b0;
        end else begin
            reading_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    spi_cs_n <= 1'b1;
                    spi_clk  <= 1'b0;
                    if (idle_cnt == IDLE_LAST) begin
                        // Frame start: start bit goes out with CS falling
                        idle_cnt <= '0;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= XFER;
                        spi_cs_n <= 1'b0;
                        spi_mosi <= 1'b1;
                        cmd_sr   <= {1'b1, ODD_BIT, 1'b1};
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                XFER: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        if (!spi_clk) begin
                            spi_clk <= 1'b1;
                            bit_cnt <= bit_cnt + 5'd1;
                            // k=6..17 carry B11..B0
                            if (bit_cnt >= 5'd5)
                                shreg <= {shreg[10:0], spi_miso};
                        end else begin
                            spi_clk <= 1'b0;
                            if (bit_cnt == 5'd17) begin
                                spi_cs_n       <= 1'b1;
                                spi_mosi       <= 1'b0;
                                sensor_reading <= shreg;
                                reading_valid  <= 1'b1;
                                state          <= IDLE;
                            end else begin
                                spi_mosi <= cmd_sr[2];
                                cmd_sr   <= {cmd_sr[1:0], 1'b0};
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcp3202_adc_reader.sv
`timescale 1ns/1ps
// Bench for mcp3202_adc_reader: scoreboarded conversions plus
// frame timing, command bits and mid-frame reset behaviour.
module tb_mcp3202_adc_reader;

    logic        sys_clk = 1'b0;
    logic        sys_reset_n;
    logic        spi_clk;
    logic        spi_miso;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic [11:0] sensor_reading;
    logic        reading_valid;

    int errors = 0;
    int checks = 0;

    logic [11:0] sb[$];
    logic [3:0]  cmd_exp = 4'b1101;

    int   cyc = 0;
    int   last_valid = -1;
    int   cs_hi = 0;
    int   kcnt = 0;
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b0;
    logic prev_valid = 1'b0;
    bit   first_seen = 1'b0;

    always #5 sys_clk = ~sys_clk;

    mcp3202_adc_reader dut (
        .sys_clk       (sys_clk),
        .sys_reset_n   (sys_reset_n),
        .spi_clk       (spi_clk),
        .spi_miso      (spi_miso),
        .spi_mosi      (spi_mosi),
        .spi_cs_n      (spi_cs_n),
        .sensor_reading(sensor_reading),
        .reading_valid (reading_valid)
    );

    task automatic chk(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs_n"}, {11'd0, spi_cs_n}, 12'd1);
        chk({tag, "_sclk"}, {11'd0, spi_clk}, 12'd0);
        chk({tag, "_mosi"}, {11'd0, spi_mosi}, 12'd0);
        chk({tag, "_reading"}, sensor_reading, 12'd0);
        chk({tag, "_valid"}, {11'd0, reading_valid}, 12'd0);
    endtask

    task automatic wait_valid(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 1200 && !got; i++) begin
            @(negedge sys_clk);
            if (reading_valid === 1'b1) got = 1'b1;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s timeout got=no_valid want=valid", tag);
        end
    endtask

    // Monitor: scoreboard pops plus frame timing checks
    always @(negedge sys_clk) begin
        logic [11:0] exp;
        cyc++;
        if (sys_reset_n !== 1'b1) begin
            last_valid = -1;
            cs_hi      = 0;
            kcnt       = 0;
            prev_cs    = 1'b1;
            prev_sclk  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_valid) begin
                checks++;
                assert (reading_valid === 1'b0) else begin
                    errors++;
                    $error("FAIL valid_width got=%b want=0", reading_valid);
                end
            end
            if (reading_valid === 1'b1) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_valid got=1 want=0");
                end
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    checks++;
                    assert (sensor_reading === exp) else begin
                        errors++;
                        $error("FAIL reading got=%h want=%h",
                               sensor_reading, exp);
                    end
                end
                if (last_valid >= 0) begin
                    checks++;
                    assert (cyc - last_valid == 554) else begin
                        errors++;
                        $error("FAIL frame_period got=%0d want=554",
                               cyc - last_valid);
                    end
                end
                if (!first_seen) begin
                    first_seen = 1'b1;
                    checks++;
                    assert ($time == 5560) else begin
                        errors++;
                        $error("FAIL first_valid_time got=%0t want=5560",
                               $time);
                    end
                end
                last_valid = cyc;
            end
            if (spi_cs_n === 1'b1) cs_hi++;
            if (prev_cs && spi_cs_n === 1'b0) begin
                checks++;
                assert (cs_hi == 10) else begin
                    errors++;
                    $error("FAIL cs_high_cycles got=%0d want=10", cs_hi);
                end
                cs_hi = 0;
                kcnt  = 0;
            end
            if (!prev_sclk && spi_clk === 1'b1) begin
                logic want;
                kcnt++;
                want = (kcnt <= 4) ? cmd_exp[4-kcnt] : 1'b0;
                checks++;
                assert (spi_mosi === want) else begin
                    errors++;
                    $error("FAIL mosi_k%0d got=%b want=%b",
                           kcnt, spi_mosi, want);
                end
            end
            if (!prev_cs && spi_cs_n === 1'b1) begin
                checks++;
                assert (kcnt == 17) else begin
                    errors++;
                    $error("FAIL sclk_pulses got=%0d want=17", kcnt);
                end
            end
            prev_cs    = spi_cs_n;
            prev_sclk  = spi_clk;
            prev_valid = reading_valid;
        end
    end

    initial begin
        logic [11:0] exp_first;
        int t;
        sys_reset_n = 1'b0;
        spi_miso    = 1'b0;

        #10;
        chk_reset_outputs("reset");

        // MISO toggles every 2000 ns; bit n is sampled at 1875+320n ns
        exp_first = '0;
        for (int n = 0; n < 12; n++) begin
            t = 1875 + 320 * n;
            exp_first = {exp_first[10:0], 1'((t / 2000) % 2)};
        end
        chk("expected_first_model", exp_first, 12'h7E0);
        sb.push_back(exp_first);

        #6 sys_reset_n = 1'b1;
        #1984 spi_miso = 1'b1;
        #2000 spi_miso = 1'b0;
        wait_valid("frame1");

        spi_miso = 1'b1;
        sb.push_back(12'hFFF);
        wait_valid("ones_a");
        sb.push_back(12'hFFF);
        wait_valid("ones_b");

        spi_miso = 1'b0;
        sb.push_back(12'h000);
        wait_valid("zeros_a");
        sb.push_back(12'h000);
        wait_valid("zeros_b");

        // Abort a frame just after SCLK rising edge 8
        spi_miso = 1'b1;
        repeat (250) @(negedge sys_clk);
        #1;
        checks++;
        assert (kcnt == 8) else begin
            errors++;
            $error("FAIL pre_abort_k got=%0d want=8", kcnt);
        end
        sys_reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (3) @(posedge sys_clk);
        #1 sys_reset_n = 1'b1;

        sb.push_back(12'hFFF);
        wait_valid("after_reset");

        repeat (2) @(negedge sys_clk);
        chk("sb_drained", 12'(sb.size()), 12'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
